// File: rtl/pdp8_trace.sv
// PDP-8 instruction trace ring: captures {pc, ir, l, ac, ion} on each fetch and
// pops oldest-first. Optional PC breakpoint freeze enabled by PDP8_TRACE_BREAK_EN.
module pdp8_trace #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  fetch_i,
  input  logic [11:0]           pc_i,
  input  logic [11:0]           ir_i,
  input  logic                  l_i,
  input  logic [11:0]           ac_i,
  input  logic                  ion_i,
  input  logic                  trace_en_i,
  input  logic                  clear_i,
  input  logic                  rd_strobe_i,
  output logic [37:0]           rd_data_o,
  output logic                  rd_valid_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  overflow_o,
  input  logic                  bp_en_i,
  input  logic [11:0]           bp_addr_i,
  output logic                  frozen_o
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PtrOne   = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0]   CntOne   = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0]   CntFull  = {1'b1, {DEPTH_LOG2{1'b0}}};

  if (DEPTH_LOG2 < 2 || DEPTH_LOG2 > 8) begin : gen_bad_depth
    $error("pdp8_trace: DEPTH_LOG2 must be in 2..8");
  end

  logic [37:0]           ram_q [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic [37:0]           rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  frozen;

  logic [37:0] entry;
  logic        capture;
  logic        pop;
  logic        full;
  logic        ram_we;

  assign entry   = {pc_i, ir_i, l_i, ac_i, ion_i};
  assign capture = fetch_i && trace_en_i && !frozen;
  assign pop     = rd_strobe_i && (count_q != '0);
  assign full    = (count_q == CntFull);
  // Reset and clear both discard a capture on the same edge.
  assign ram_we  = capture && !reset_i && !clear_i;

`ifdef PDP8_TRACE_BREAK_EN
  logic frozen_q, frozen_d;
  logic bp_hit;

  assign frozen = frozen_q;
  assign bp_hit = capture && bp_en_i && (pc_i == bp_addr_i);

  always_comb begin
    frozen_d = frozen_q;
    if (clear_i) begin
      frozen_d = 1'b0;
    end else if (bp_hit) begin
      frozen_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      frozen_q <= 1'b0;
    end else begin
      frozen_q <= frozen_d;
    end
  end
`else
  logic unused_bp;

  assign frozen    = 1'b0;
  assign unused_bp = ^{bp_en_i, bp_addr_i};
`endif

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;

    if (clear_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (pop) begin
        // Read happens before this edge's write, so a same-cycle capture
        // into a full ring cannot clobber the entry being popped.
        rd_data_d  = ram_q[rd_ptr_q];
        rd_valid_d = 1'b1;
        rd_ptr_d   = rd_ptr_q + PtrOne;
      end

      if (capture) begin
        wr_ptr_d = wr_ptr_q + PtrOne;
        if (full && !pop) begin
          rd_ptr_d   = rd_ptr_q + PtrOne;
          overflow_d = 1'b1;
        end
      end

      if (capture && !pop && !full) begin
        count_d = count_q + CntOne;
      end else if (pop && !capture) begin
        count_d = count_q - CntOne;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (ram_we) begin
      ram_q[wr_ptr_q] <= entry;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;
  assign frozen_o   = frozen;

endmodule

// File: tb/tb_pdp8_trace.sv
// Randomised scoreboard bench for pdp8_trace against a queue-based trace model.
// Define PDP8_TRACE_BREAK_EN for both RTL and bench to exercise the breakpoint.
module tb_pdp8_trace;

  localparam int DL    = 4;
  localparam int Depth = 16;
`ifdef PDP8_TRACE_BREAK_EN
  localparam int BpExpCount  = 6;
  localparam int BpExpFrozen = 1;
`else
  localparam int BpExpCount  = 9;
  localparam int BpExpFrozen = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0, fetch = 1'b0, l = 1'b0, ion = 1'b0, trace_en = 1'b0;
  logic        clear = 1'b0, rd_strobe = 1'b0, bp_en = 1'b0;
  logic [11:0] pc = '0, ir = '0, ac = '0, bp_addr = '0;
  logic [37:0] rd_data;
  logic        rd_valid, overflow, frozen;
  logic [DL:0] count;

  pdp8_trace #(.DEPTH_LOG2(DL)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .fetch_i     (fetch),
    .pc_i        (pc),
    .ir_i        (ir),
    .l_i         (l),
    .ac_i        (ac),
    .ion_i       (ion),
    .trace_en_i  (trace_en),
    .clear_i     (clear),
    .rd_strobe_i (rd_strobe),
    .rd_data_o   (rd_data),
    .rd_valid_o  (rd_valid),
    .count_o     (count),
    .overflow_o  (overflow),
    .bp_en_i     (bp_en),
    .bp_addr_i   (bp_addr),
    .frozen_o    (frozen)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [37:0] data;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  logic [37:0] model_q[$];
  logic        m_ovf = 1'b0, m_frz = 1'b0;
  logic [37:0] m_rdata = '0;
  int          checks = 0, errors = 0;

  task automatic check(input string name, input logic [37:0] act, input logic [37:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents rd_valid.
  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
      checks++;
      errors++;
      $display("FAIL rd_missing: no rd_valid for pc %0o due cycle %0d", exp_q[0].data[37:26],
               exp_q[0].due);
      void'(exp_q.pop_front());
    end
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_spurious: rd_valid=1 expected 0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rd_latency", 38'(cyc), 38'(e.due));
        check("rd_data", rd_data, e.data);
      end
    end
  end

  // Applies the trace rules to the model for the inputs now driven, then clocks
  // the DUT and checks the architectural state.
  task automatic tick();
    logic [37:0] entry;
    bit          cap, pop;
    entry = {pc, ir, l, ac, ion};
    if (reset) begin
      model_q.delete();
      m_ovf   = 1'b0;
      m_frz   = 1'b0;
      m_rdata = '0;
    end else if (clear) begin
      model_q.delete();
      m_ovf = 1'b0;
      m_frz = 1'b0;
    end else begin
      cap = fetch && trace_en && !m_frz;
      pop = rd_strobe && (model_q.size() > 0);
      if (pop) begin
        exp_t e;
        e.data  = model_q.pop_front();
        e.due   = cyc + 1;
        m_rdata = e.data;
        exp_q.push_back(e);
      end
      if (cap) begin
        if (model_q.size() == Depth) begin
          void'(model_q.pop_front());
          m_ovf = 1'b1;
        end
        model_q.push_back(entry);
`ifdef PDP8_TRACE_BREAK_EN
        if (bp_en && pc == bp_addr) m_frz = 1'b1;
`endif
      end
    end
    @(posedge clk);
    #1;
    check("count", 38'(count), 38'(model_q.size()));
    check("overflow", 38'(overflow), 38'(m_ovf));
    check("frozen", 38'(frozen), 38'(m_frz));
    check("rd_data_hold", rd_data, m_rdata);
    if (reset) check("reset_rd_valid", 38'(rd_valid), 38'(0));
    fetch     = 1'b0;
    rd_strobe = 1'b0;
    clear     = 1'b0;
    reset     = 1'b0;
  endtask

  task automatic set_fetch(input logic [11:0] pcv);
    fetch = 1'b1;
    pc    = pcv;
    ir    = 12'($urandom);
    ac    = 12'($urandom);
    l     = 1'($urandom);
    ion   = 1'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && model_q.size() > 0; i++) begin
      rd_strobe = 1'b1;
      tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    tick();
    check("reset_count", 38'(count), 38'(0));
    trace_en = 1'b1;

    // Three fetches then three pops, in order.
    for (int i = 0; i < 3; i++) begin
      set_fetch(12'o200 + 12'(i));
      tick();
    end
    check("three_count", 38'(count), 38'(3));
    for (int i = 0; i < 3; i++) begin
      rd_strobe = 1'b1;
      tick();
      check("three_pc", 38'(rd_data[37:26]), 38'(12'o200 + 12'(i)));
    end

    // Empty pop and disabled capture.
    rd_strobe = 1'b1;
    tick();
    trace_en = 1'b0;
    set_fetch(12'o300);
    tick();
    check("disabled_count", 38'(count), 38'(0));
    trace_en = 1'b1;

    // Overrun: 18 fetches into 16 slots.
    for (int i = 0; i < 18; i++) begin
      set_fetch(12'(i));
      tick();
    end
    check("ovr_count", 38'(count), 38'(16));
    check("ovr_flag", 38'(overflow), 38'(1));
    rd_strobe = 1'b1;
    tick();
    check("ovr_first_pc", 38'(rd_data[37:26]), 38'(12'o2));
    drain();
    check("ovr_last_pc", 38'(rd_data[37:26]), 38'(12'o21));

    // Full ring with simultaneous capture and pop.
    clear = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      set_fetch(12'o400 + 12'(i));
      tick();
    end
    set_fetch(12'o777);
    rd_strobe = 1'b1;
    tick();
    check("full_pop_count", 38'(count), 38'(16));
    check("full_pop_ovf", 38'(overflow), 38'(0));
    check("full_pop_pc", 38'(rd_data[37:26]), 38'(12'o400));

    // Breakpoint at 0205.
    clear = 1'b1;
    tick();
    bp_en   = 1'b1;
    bp_addr = 12'o205;
    for (int i = 0; i < 9; i++) begin
      set_fetch(12'o200 + 12'(i));
      tick();
    end
    check("bp_count", 38'(count), 38'(BpExpCount));
    check("bp_frozen", 38'(frozen), 38'(BpExpFrozen));
    drain();
    check("bp_last_pc", 38'(rd_data[37:26]), 38'(BpExpFrozen != 0 ? 12'o205 : 12'o210));
    clear = 1'b1;
    tick();
    check("bp_clear_frozen", 38'(frozen), 38'(0));
    bp_en = 1'b0;

    // Reset mid-operation with a pending pop.
    for (int i = 0; i < 5; i++) begin
      set_fetch(12'o1000 + 12'(i));
      tick();
    end
    reset     = 1'b1;
    rd_strobe = 1'b1;
    tick();
    check("mid_reset_count", 38'(count), 38'(0));

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      trace_en = ($urandom_range(0, 9) != 0);
      bp_en    = 1'($urandom);
      bp_addr  = 12'($urandom_range(0, 31));
      if ($urandom_range(0, 2) != 0) set_fetch(12'($urandom_range(0, 31)));
      rd_strobe = ($urandom_range(0, 2) == 0);
      clear     = ($urandom_range(0, 59) == 0);
      reset     = ($urandom_range(0, 249) == 0);
      tick();
    end

    bp_en = 1'b0;
    drain();
    tick();
    tick();
    check("scoreboard_drain", 38'(exp_q.size()), 38'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
